// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin arbiter sharing one pipelined fixed-point multiplier
// Grants one requester per cycle, registers its operands, and returns the tagged product.
module fp_mult_arbiter #(
  parameter int W_len    = 16,
  parameter int W_fract  = 14,
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*W_len-1:0]        req_a,
  input  logic [N_REQ*W_len-1:0]        req_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic [W_len-1:0]              mult_a,
  output logic [W_len-1:0]              mult_b,
  input  logic [W_len-1:0]              mult_product,
  input  logic                          mult_overflow,
  input  logic                          mult_underflow,
  output logic                          rsp_valid,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [W_len-1:0]              rsp_product,
  output logic                          rsp_overflow,
  output logic                          rsp_underflow,
  output logic [$clog2(MULT_LAT+2)-1:0] in_flight
);

  localparam int IW    = $clog2(N_REQ);
  localparam int FW    = $clog2(MULT_LAT+2);
  localparam int DEPTH = MULT_LAT + 1;

  if (N_REQ < 2 || N_REQ > 8 || MULT_LAT < 1 || W_fract >= W_len) begin : g_bad_params
    $error("fp_mult_arbiter: unsupported parameter set");
  end

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;
  logic [W_len-1:0] sel_a;
  logic [W_len-1:0] sel_b;
  logic [DEPTH-1:0] tag_valid;
  logic [IW-1:0]    tag_id [DEPTH];
  logic             tail_valid;

  always_comb begin
    int          j;
    logic [IW-1:0] idx;
    req_ready = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IW'(j);
      if (!gnt_valid && req_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
    if (gnt_valid) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_a    = req_a[gnt_id*W_len +: W_len];
    sel_b    = req_b[gnt_id*W_len +: W_len];
    ptr_next = (gnt_id == IW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
  end

  // Tag pipe is one stage longer than MULT_LAT: the operand register adds a cycle.
  assign tail_valid = tag_valid[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      tag_valid <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id[k] <= '0;
    end else begin
      if (gnt_valid) begin
        mult_a <= sel_a;
        mult_b <= sel_b;
        ptr    <= ptr_next;
      end
      tag_valid <= {tag_valid[DEPTH-2:0], gnt_valid};
      tag_id[0] <= gnt_id;
      for (int k = 1; k < DEPTH; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_product   <= '0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
    end else begin
      rsp_valid <= tail_valid;
      if (tail_valid) begin
        rsp_id        <= tag_id[DEPTH-1];
        rsp_product   <= mult_product;
        rsp_overflow  <= mult_overflow;
        rsp_underflow <= mult_underflow;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      case ({gnt_valid, tail_valid})
        2'b10:   in_flight <= in_flight + FW'(1);
        2'b01:   in_flight <= in_flight - FW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
